// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sp_boot memory slice.
// Optional parity storage is selected by the RAM_PARITY_EN macro in the users of this package.
package ram_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int unsigned RDW_WRITE_FIRST = 0;
    localparam int unsigned RDW_READ_FIRST  = 1;

    localparam int unsigned PARITY_MAX_W = 64;

    // Even parity bit: set when the word has an odd number of ones.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Bare single-port inferred RAM: synchronous write, registered read,
// read-during-write behaviour chosen by RDW_MODE.
module ram_sp_core
    import ram_pkg::*;
#(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RDW_MODE = RDW_WRITE_FIRST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Read register is kept separate from the array so the array stays resetless.
    always_ff @(posedge clock) begin
        if (reset)
            rdata <= '0;
        else if (re) begin
            if (we && (RDW_MODE != RDW_READ_FIRST))
                rdata <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_sp_boot.sv
// Single-port RAM with post-reset clear sequencer, streaming boot-load port and read-valid strobe.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose parity_err / inject_err.
module ram_sp_boot
    import ram_pkg::*;
#(
    parameter int unsigned     DATA_W    = 16,
    parameter int unsigned     ADDR_W    = 8,
    parameter int unsigned     RDW_MODE  = RDW_WRITE_FIRST,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_last,
    output logic              load_done
`ifdef RAM_PARITY_EN
    ,
    input  logic              inject_err,
    output logic              parity_err
`endif
);

`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [WORD_W-1:0] mem_wword;
    logic [WORD_W-1:0] mem_rword;
`ifdef RAM_PARITY_EN
    logic              mem_inj;
`endif

    // Sequencer owns the port in CLEAR/LOAD; the CPU only reaches it in IDLE.
    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = ptr;
        mem_data = CLEAR_VAL;
`ifdef RAM_PARITY_EN
        mem_inj  = 1'b0;
`endif
        if (!reset) begin
            case (state)
                CLEAR: mem_we = 1'b1;
                IDLE: begin
                    mem_we   = we;
                    mem_re   = we | re;
                    mem_addr = addr;
                    mem_data = din;
`ifdef RAM_PARITY_EN
                    mem_inj  = inject_err;
`endif
                end
                LOAD: begin
                    mem_we   = load_valid;
                    mem_data = load_data;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

`ifdef RAM_PARITY_EN
    assign mem_wword  = {even_parity(PARITY_MAX_W'(mem_data)) ^ mem_inj, mem_data};
    assign parity_err = dout_valid &&
                        (even_parity(PARITY_MAX_W'(mem_rword[DATA_W-1:0])) != mem_rword[DATA_W]);
`else
    assign mem_wword  = mem_data;
`endif
    assign dout = mem_rword[DATA_W-1:0];

    ram_sp_core #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wword),
        .rdata (mem_rword)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            ptr        <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            dout_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == '1) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    dout_valid <= we | re;
                    if (load_start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (load_last || (ptr == '1)) begin
                            state      <= IDLE;
                            ptr        <= '0;
                            busy       <= 1'b0;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_boot.sv
// Self-checking bench for ram_sp_boot: one write-first and one read-first instance share stimulus.
// Parity checks are compiled in when RAM_PARITY_EN is defined.
module tb_ram_sp_boot;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic [7:0]  addr = '0;
    logic        we = 1'b0, re = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [15:0] load_data = '0;

    logic [15:0] dout0, dout1;
    logic        dv0, dv1, busy0, busy1, lr0, lr1, ld0, ld1;
`ifdef RAM_PARITY_EN
    logic        inject_err = 1'b0;
    logic        pe0, pe1;
`endif

    always #5 clock = ~clock;

    ram_sp_boot #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(0), .CLEAR_VAL(16'h0000)) dut0 (
        .clock(clock), .reset(reset), .din(din), .addr(addr), .we(we), .re(re),
        .dout(dout0), .dout_valid(dv0), .busy(busy0),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr0), .load_last(load_last), .load_done(ld0)
`ifdef RAM_PARITY_EN
        , .inject_err(inject_err), .parity_err(pe0)
`endif
    );

    ram_sp_boot #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(1), .CLEAR_VAL(16'h0000)) dut1 (
        .clock(clock), .reset(reset), .din(din), .addr(addr), .we(we), .re(re),
        .dout(dout1), .dout_valid(dv1), .busy(busy1),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr1), .load_last(load_last), .load_done(ld1)
`ifdef RAM_PARITY_EN
        , .inject_err(inject_err), .parity_err(pe1)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: memory image plus a few counters describing what the outputs must be.
    logic [15:0] m_mem [256];
    bit          m_bad [256];
    int          m_clear_left = 0;
    bit          m_loading = 0;
    int          m_lptr = 0;
    bit          started = 0;
    logic [15:0] e_dout0 = '0, e_dout1 = '0;
    bit          e_valid = 0, e_done = 0, e_busy = 1;
    bit          e_pe0 = 0, e_pe1 = 0;

    always @(posedge clock) begin
        logic [15:0] old;
        bit          old_bad, inj;
`ifdef RAM_PARITY_EN
        inj = inject_err;
`else
        inj = 1'b0;
`endif
        if (reset) begin
            started = 1;
            m_clear_left = 256;
            m_loading = 0;
            m_lptr = 0;
            e_busy = 1; e_valid = 0; e_done = 0; e_pe0 = 0; e_pe1 = 0;
            e_dout0 = '0; e_dout1 = '0;
        end else begin
            e_valid = 0; e_done = 0; e_pe0 = 0; e_pe1 = 0;
            if (m_clear_left > 0) begin
                m_mem[256 - m_clear_left] = 16'h0000;
                m_bad[256 - m_clear_left] = 0;
                m_clear_left--;
                if (m_clear_left == 0) e_busy = 0;
            end else if (m_loading) begin
                if (load_valid) begin
                    m_mem[m_lptr] = load_data;
                    m_bad[m_lptr] = 0;
                    if (load_last || m_lptr == 255) begin
                        m_loading = 0; e_busy = 0; e_done = 1;
                    end
                    m_lptr = (m_lptr + 1) % 256;
                end
            end else begin
                if (we || re) begin
                    old = m_mem[addr];
                    old_bad = m_bad[addr];
                    if (we) begin
                        m_mem[addr] = din;
                        m_bad[addr] = inj;
                    end
                    e_dout0 = we ? din : old;
                    e_dout1 = old;
                    e_pe0 = we ? inj : old_bad;
                    e_pe1 = old_bad;
                    e_valid = 1;
                end
                if (load_start) begin
                    m_loading = 1; e_busy = 1; m_lptr = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("busy0", busy0, e_busy);
            check("busy1", busy1, e_busy);
            check("load_ready", lr0 & lr1, m_loading);
            check("load_done", {ld1, ld0}, {e_done, e_done});
            check("dout_valid", {dv1, dv0}, {e_valid, e_valid});
            check("dout_wf", dout0, e_dout0);
            check("dout_rf", dout1, e_dout1);
`ifdef RAM_PARITY_EN
            check("parity_err_wf", pe0, e_pe0);
            check("parity_err_rf", pe1, e_pe1);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu(input bit w, input bit r, input logic [7:0] a, input logic [15:0] d);
        we = w; re = r; addr = a; din = d;
        tick();
        we = 0; re = 0;
    endtask

    task automatic read_lit(input string n, input logic [7:0] a, input logic [15:0] exp);
        cpu(0, 1, a, 16'h0000);
        check({n, "_valid"}, dv0, 1'b1);
        check({n, "_wf"}, dout0, exp);
        check({n, "_rf"}, dout1, exp);
    endtask

    task automatic wait_clear(input string n);
        int cnt = 0;
        while (busy0 && cnt < 400) begin
            cnt++;
            tick();
        end
        check(n, cnt, 256);
    endtask

    task automatic start_load();
        load_start = 1;
        tick();
        load_start = 0;
    endtask

    task automatic beat(input logic [15:0] d, input bit last, input int gap);
        repeat (gap) tick();
        load_valid = 1; load_data = d; load_last = last;
        tick();
        load_valid = 0; load_last = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] lw [3];
        lw[0] = 16'hA006; lw[1] = 16'h400A; lw[2] = 16'h9C04;

        tick(); tick();
        reset = 0;
        check("reset_busy", busy0, 1'b1);
        check("reset_dout", dout0, 16'h0000);
        wait_clear("clear_cycles");
        read_lit("rd0", 8'd0, 16'h0000);
        read_lit("rd127", 8'd127, 16'h0000);
        read_lit("rd255", 8'd255, 16'h0000);

        // Three-beat boot load
        start_load();
        check("load_ready_lit", lr0, 1'b1);
        for (int i = 0; i < 3; i++) beat(lw[i], i == 2, 0);
        check("load_done_pulse", ld0, 1'b1);
        check("busy_after_load", busy0, 1'b0);
        tick();
        check("load_done_clear", ld0, 1'b0);
        read_lit("ld_rd0", 8'd0, 16'hA006);
        read_lit("ld_rd1", 8'd1, 16'h400A);
        read_lit("ld_rd2", 8'd2, 16'h9C04);
        read_lit("ld_rd3", 8'd3, 16'h0000);

        // Read-during-write on the same address
        cpu(1, 0, 8'd5, 16'h1111);
        cpu(1, 1, 8'd5, 16'h2222);
        check("rdw_wf", dout0, 16'h2222);
        check("rdw_rf", dout1, 16'h1111);
        read_lit("rdw_after", 8'd5, 16'h2222);

        // CPU access dropped while loading; gapped load
        cpu(1, 0, 8'd9, 16'h0999);
        start_load();
        we = 1; re = 1; addr = 8'd9; din = 16'hDEAD;
        tick();
        we = 0; re = 0;
        check("busy_write_valid", dv0, 1'b0);
        for (int i = 0; i < 6; i++) beat(16'h5A00 + 16'(i), i == 5, i % 4);
        tick();
        for (int i = 0; i < 6; i++) read_lit("gap_rd", 8'(i), 16'h5A00 + 16'(i));
        read_lit("rd9_kept", 8'd9, 16'h0999);

        // Reset in the middle of a long load
        start_load();
        for (int i = 0; i < 100; i++) beat(16'h1000 + 16'(i), 1'b0, 0);
        check("mid_load_ready", lr0, 1'b1);
        reset = 1;
        tick();
        reset = 0;
        check("mid_reset_ready", lr0, 1'b0);
        wait_clear("reclear_cycles");
        read_lit("rd50_cleared", 8'd50, 16'h0000);
        read_lit("rd0_cleared", 8'd0, 16'h0000);

`ifdef RAM_PARITY_EN
        inject_err = 1;
        cpu(1, 0, 8'd4, 16'h00FF);
        inject_err = 0;
        cpu(0, 1, 8'd4, 16'h0000);
        check("parity_inj", pe0, 1'b1);
        cpu(1, 0, 8'd4, 16'h00FF);
        cpu(0, 1, 8'd4, 16'h0000);
        check("parity_clean", pe0, 1'b0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
